load_store_unit: RTL and testbench

Multi-cycle load/store unit sitting directly downstream of the datapath ALU: it consumes the effective address (`alu_out`) and store data (`data_out2`), performs a handshaked access to the data memory, and returns a sign/zero-extended load result for register writeback. While an access is in flight it holds `stall` high so the datapath deasserts `pc_write`. It detects misaligned and illegal-width accesses without touching memory.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state encoding and
// base byte-enable patterns. Also used by the planned store buffer.
package lsu_pkg;

  // funct3 width codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // FSM state encoding
  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t StIdle   = 2'd0;
  localparam lsu_state_t StAccess = 2'd1;
  localparam lsu_state_t StDone   = 2'd2;
  localparam lsu_state_t StErr    = 2'd3;

  // Byte enables for lane 0; shifted by the byte offset
  localparam logic [3:0] BeByte = 4'b0001;
  localparam logic [3:0] BeHalf = 4'b0011;
  localparam logic [3:0] BeWord = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational access aligner.
// Ports:
//   addr_lo_i   - byte offset within the word
//   funct3_i    - RV32I width code
//   write_i     - 1 = store
//   wdata_i     - raw store data
//   mem_rdata_i - raw memory read word
//   be_o        - byte enables for the access
//   wdata_o     - lane-replicated store data
//   rdata_o     - extracted, sign/zero-extended load data
//   legal_o     - access is well-formed and aligned
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        legal_o
);

  logic [31:0] lane;

  // Move the addressed byte/half down to bit 0
  assign lane = mem_rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o    = '0;
    wdata_o = wdata_i;
    rdata_o = '0;
    legal_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = BeByte << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = funct3_i[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        legal_o = 1'b1;
      end
      2'b01: begin
        be_o    = BeHalf << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = funct3_i[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        legal_o = ~addr_lo_i[0];
      end
      2'b10: begin
        be_o    = BeWord;
        wdata_o = wdata_i;
        rdata_o = lane;
        // There is no LWU in RV32I
        legal_o = (addr_lo_i == 2'b00) && !funct3_i[2];
      end
      default: legal_o = 1'b0;
    endcase
    // Unsigned codes have no store counterpart
    if (write_i && funct3_i[2]) legal_o = 1'b0;
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the ALU and the data memory.
// Ports:
//   clk, reset                  - clock, asynchronous active-low reset
//   ls_valid/ls_write/funct3    - request from the datapath (held until ls_done)
//   addr, wdata                 - byte address and store data
//   rdata, ls_done, ls_error    - extended load result, completion pulse, error flag
//   stall                       - datapath must hold the PC
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata - registered memory request
//   mem_ready, mem_rdata        - memory handshake and read word
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ls_valid,
  input  logic              ls_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ls_done,
  output logic              ls_error,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        is_idle;
  logic [1:0]  al_off;
  logic [2:0]  al_f3;
  logic        al_write;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_legal;

  assign is_idle = (state_q == StIdle);

  // In IDLE the aligner checks the incoming request; afterwards it decodes the latched one
  assign al_off   = is_idle ? addr[1:0] : off_q;
  assign al_f3    = is_idle ? funct3 : f3_q;
  assign al_write = is_idle ? ls_write : we_q;

  lsu_align u_align (
    .addr_lo_i   (al_off),
    .funct3_i    (al_f3),
    .write_i     (al_write),
    .wdata_i     (wdata),
    .mem_rdata_i (mem_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata),
    .legal_o     (al_legal)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    f3_d    = f3_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (ls_valid) begin
          rdata_d = '0;
          if (!al_legal) begin
            state_d = StErr;
          end else begin
            state_d = StAccess;
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            off_d   = addr[1:0];
            f3_d    = funct3;
            we_d    = ls_write;
            be_d    = al_be;
            wdata_d = al_wdata;
          end
        end
      end
      StAccess: begin
        if (mem_ready) begin
          state_d = StDone;
          rdata_d = we_q ? 32'b0 : al_rdata;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_req   = (state_q == StAccess);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign ls_done   = (state_q == StDone) || (state_q == StErr);
  assign ls_error  = (state_q == StErr);
  assign stall     = (is_idle && ls_valid) || (state_q == StAccess);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ls_valid, ls_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ls_done, ls_error, stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .ls_valid  (ls_valid),
    .ls_write  (ls_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ls_done   (ls_done),
    .ls_error  (ls_error),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          waits;
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] mrd, int waits, logic err, logic [3:0] be,
                              logic [31:0] mwd, logic [31:0] rd);
    vec_t v;
    v.write = w; v.f3 = f3; v.addr = a; v.wdata = wd; v.mrd = mrd; v.waits = waits;
    v.err = err; v.be = be; v.mwd = mwd; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    ls_valid = 1'b1;
    ls_write = v.write;
    funct3   = v.f3;
    addr     = v.addr;
    wdata    = v.wdata;
    #1;
    chk($sformatf("v%0d stall_req", idx), {31'b0, stall}, 32'd1);
    step();  // accept edge
    if (v.err) begin
      chk($sformatf("v%0d err_done", idx), {31'b0, ls_done}, 32'd1);
      chk($sformatf("v%0d err_flag", idx), {31'b0, ls_error}, 32'd1);
      chk($sformatf("v%0d err_req", idx), {31'b0, mem_req}, 32'd0);
      chk($sformatf("v%0d err_rdata", idx), rdata, 32'd0);
      chk($sformatf("v%0d err_stall", idx), {31'b0, stall}, 32'd0);
    end else begin
      chk($sformatf("v%0d req", idx), {31'b0, mem_req}, 32'd1);
      chk($sformatf("v%0d we", idx), {31'b0, mem_we}, {31'b0, v.write});
      chk($sformatf("v%0d addr", idx), mem_addr, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d be", idx), {28'b0, mem_be}, {28'b0, v.be});
      if (v.write) chk($sformatf("v%0d wdata", idx), mem_wdata, v.mwd);
      for (int w = 0; w < v.waits; w++) begin
        mem_ready = 1'b0;
        step();
        chk($sformatf("v%0d wait%0d req", idx, w), {31'b0, mem_req}, 32'd1);
        chk($sformatf("v%0d wait%0d stall", idx, w), {31'b0, stall}, 32'd1);
        chk($sformatf("v%0d wait%0d done", idx, w), {31'b0, ls_done}, 32'd0);
        chk($sformatf("v%0d wait%0d addr", idx, w), mem_addr, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d wait%0d be", idx, w), {28'b0, mem_be}, {28'b0, v.be});
      end
      mem_ready = 1'b1;
      mem_rdata = v.mrd;
      step();
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      chk($sformatf("v%0d done", idx), {31'b0, ls_done}, 32'd1);
      chk($sformatf("v%0d error", idx), {31'b0, ls_error}, 32'd0);
      chk($sformatf("v%0d rdata", idx), rdata, v.rd);
      chk($sformatf("v%0d done_stall", idx), {31'b0, stall}, 32'd0);
      chk($sformatf("v%0d done_req", idx), {31'b0, mem_req}, 32'd0);
    end
    ls_valid = 1'b0;
    step();  // back in IDLE
    chk($sformatf("v%0d idle_done", idx), {31'b0, ls_done}, 32'd0);
    chk($sformatf("v%0d idle_req", idx), {31'b0, mem_req}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; ls_valid = 1'b0; ls_write = 1'b0; funct3 = 3'b0;
    addr = 32'h0; wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;

    //          w     f3      addr          wdata         mem_rdata     wt err be       mem_wdata     rdata
    vecs[0]  = mk(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    vecs[1]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0, 0, 4'b1000, 32'h0,         32'hFFFF_FF80);
    vecs[2]  = mk(1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0, 0, 4'b1000, 32'h0,         32'h0000_0080);
    vecs[3]  = mk(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0,         0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0);
    vecs[4]  = mk(1'b0, 3'b101, 32'h0000_0102, 32'h0,         32'hABCD_1234, 0, 0, 4'b1100, 32'h0,         32'h0000_ABCD);
    vecs[5]  = mk(1'b0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,         32'h0);
    vecs[6]  = mk(1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,         32'h0);
    vecs[7]  = mk(1'b0, 3'b010, 32'h0000_0200, 32'h0,         32'h1234_5678, 4, 0, 4'b1111, 32'h0,         32'h1234_5678);
    vecs[8]  = mk(1'b0, 3'b001, 32'h0000_0100, 32'h0,         32'h0000_8001, 0, 0, 4'b0011, 32'h0,         32'hFFFF_8001);
    vecs[9]  = mk(1'b1, 3'b000, 32'h0000_0101, 32'h1234_565A, 32'h0,         1, 0, 4'b0010, 32'h5A5A_5A5A, 32'h0);
    vecs[10] = mk(1'b1, 3'b100, 32'h0000_0100, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,         32'h0);
    vecs[11] = mk(1'b0, 3'b001, 32'h0000_0103, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,         32'h0);

    // Reset values
    #12;
    chk("rst rdata", rdata, 32'h0);
    chk("rst done", {31'b0, ls_done}, 32'd0);
    chk("rst error", {31'b0, ls_error}, 32'd0);
    chk("rst req", {31'b0, mem_req}, 32'd0);
    chk("rst we", {31'b0, mem_we}, 32'd0);
    chk("rst addr", mem_addr, 32'h0);
    chk("rst be", {28'b0, mem_be}, 32'h0);
    chk("rst wdata", mem_wdata, 32'h0);
    chk("rst stall", {31'b0, stall}, 32'd0);
    reset = 1'b1;
    step();

    // mem_ready outside ACCESS is ignored
    mem_ready = 1'b1;
    step();
    step();
    chk("idle ready req", {31'b0, mem_req}, 32'd0);
    chk("idle ready done", {31'b0, ls_done}, 32'd0);
    mem_ready = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset in the middle of an access abandons it
    ls_valid = 1'b1; ls_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
    step();
    chk("abort req_before", {31'b0, mem_req}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("abort req_async", {31'b0, mem_req}, 32'd0);
    chk("abort stall_follows_valid", {31'b0, stall}, 32'd1);
    ls_valid = 1'b0;
    #1;
    chk("abort stall_low", {31'b0, stall}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("abort no_done%0d", c), {31'b0, ls_done}, 32'd0);
      chk($sformatf("abort no_req%0d", c), {31'b0, mem_req}, 32'd0);
    end
    reset = 1'b1;
    step();
    run_vec(100, mk(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1, 0, 4'b1111,
                    32'h0, 32'hCAFE_F00D));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
